// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - synchronous FIFO controller using an external 8x64 dual-port RAM as storage
//
// Purpose:
//   Streams words in through RAM port A and out through RAM port B. A two-entry
//   output buffer hides the one-cycle registered RAM read so that a continuous
//   stream moves at one word per cycle.
//
// Ports:
//   clk, rst        clock shared with the RAM; synchronous active-high reset
//   flush           synchronous clear of all contents (same effect as reset)
//   in_*            write stream (in_data, in_valid, in_ready)
//   out_*           read stream (out_data, out_valid, out_ready)
//   count           words held: RAM + read in flight + output buffer (max DEPTH+2)
//   ram_*_a         RAM write port (we, addr, data)
//   ram_addr_b      RAM read address; ram_we_b is tied low
//   ram_q_b         registered RAM read data, valid one cycle after ram_addr_b
//
// Optional feature (macro RAM_FIFO_OVF_FLAG_EN):
//   ovf_err         sticky: in_valid seen while in_ready was low
//   udf_err         sticky: out_ready seen while out_valid was low

module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W+1:0] count,
    output logic [DATA_W-1:0] ram_data_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_q_b
`ifdef RAM_FIFO_OVF_FLAG_EN
    ,
    output logic              ovf_err,
    output logic              udf_err
`endif
);

    // ram_cnt equal to DEPTH means the RAM is full
    localparam logic [ADDR_W:0] RAM_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;

    logic              push;
    logic              pop;
    logic              rd_issue;
    logic [2:0]        occ_after_pop;

    assign in_ready  = (ram_cnt_q != RAM_FULL);
    assign out_valid = (buf_cnt_q != 2'd0);
    assign out_data  = buf0_q;

    // A push in a flush or reset cycle is dropped, so the RAM must not be written either
    assign push = in_valid & in_ready & ~flush & ~rst;
    assign pop  = out_valid & out_ready;

    // Slots already claimed in the buffer once this cycle's pop is applied; a new
    // read is only launched if its data will have a free slot when it returns.
    assign occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign rd_issue      = (ram_cnt_q != '0) & (occ_after_pop < 3'd2);

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr_q;
    assign ram_data_a = in_data;
    assign ram_addr_b = rd_ptr_q;
    assign ram_we_b   = 1'b0;

    assign count = {1'b0, ram_cnt_q}
                 + {{(ADDR_W+1){1'b0}}, rd_pend_q}
                 + {{ADDR_W{1'b0}}, buf_cnt_q};

    always_comb begin
        wr_ptr_d  = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d  = rd_ptr_q + ADDR_W'(rd_issue);
        ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(rd_issue);
        rd_pend_d = rd_issue;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;

        if (pop) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end

        // Returning read data lands in the first free slot after the pop shift
        if (rd_pend_q) begin
            if (buf_cnt_d == 2'd0) begin
                buf0_d = ram_q_b;
            end else begin
                buf1_d = ram_q_b;
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            rd_pend_d = 1'b0;
            buf0_d    = '0;
            buf1_d    = '0;
            buf_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            buf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pend_q <= rd_pend_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            buf_cnt_q <= buf_cnt_d;
        end
    end

`ifdef RAM_FIFO_OVF_FLAG_EN
    logic ovf_err_q, ovf_err_d;
    logic udf_err_q, udf_err_d;

    always_comb begin
        ovf_err_d = ovf_err_q | (in_valid & ~in_ready);
        udf_err_d = udf_err_q | (out_ready & ~out_valid);
        if (flush) begin
            ovf_err_d = 1'b0;
            udf_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl with a behavioural dual-port RAM

module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] count;
    logic [7:0] ram_data_a;
    logic [5:0] ram_addr_a;
    logic       ram_we_a;
    logic [5:0] ram_addr_b;
    logic       ram_we_b;
    logic [7:0] ram_q_b;
`ifdef RAM_FIFO_OVF_FLAG_EN
    logic       ovf_err;
    logic       udf_err;
`endif

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .ram_data_a (ram_data_a),
        .ram_addr_a (ram_addr_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_b (ram_addr_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b)
`ifdef RAM_FIFO_OVF_FLAG_EN
        ,
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
`endif
    );

    // Behavioural 8x64 true dual-port RAM, registered read on port B
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO is just an ordered queue of accepted words
    logic [7:0] sb [$];

    logic       o_in_ready, o_out_valid, o_we, o_push, o_pop;
    logic [7:0] o_out_data, o_count, exp_head;
    int         exp_size;

    // Drive one cycle, sample outputs at the falling edge, update the model,
    // and return just after the next rising edge.
    task automatic tick(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        o_in_ready  = in_ready;
        o_out_valid = out_valid;
        o_out_data  = out_data;
        o_count     = count;
        o_we        = ram_we_a;
        o_push      = iv & in_ready & ~fl;
        o_pop       = out_valid & ordy;
        exp_size    = sb.size();
        exp_head    = (sb.size() > 0) ? sb[0] : 8'h00;
        if (fl) begin
            sb.delete();
        end else begin
            if (o_pop && sb.size() > 0) void'(sb.pop_front());
            if (o_push) sb.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        out_ready = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", o_in_ready); end
        checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", o_out_valid); end
        checks++; if (o_out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", o_out_data); end
        checks++; if (o_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if (o_we !== 1'b0) begin failures++; $display("FAIL reset_we_a got=%0b exp=0", o_we); end
        checks++; if (ram_we_b !== 1'b0) begin failures++; $display("FAIL reset_we_b got=%0b exp=0", ram_we_b); end
    endtask

    task automatic test_basic_latency();
        do_reset();
        tick(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++; if (o_push !== 1'b1 || o_we !== 1'b1) begin failures++; $display("FAIL lat_push got=%0b/%0b exp=1/1", o_push, o_we); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (o_out_valid !== 1'b0 || o_count !== 8'd1) begin failures++; $display("FAIL lat_edge1 valid=%0b count=%0d exp 0/1", o_out_valid, o_count); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (o_out_valid !== 1'b0 || o_count !== 8'd1) begin failures++; $display("FAIL lat_edge2 valid=%0b count=%0d exp 0/1", o_out_valid, o_count); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'hAA || o_count !== 8'd1) begin
            failures++; $display("FAIL lat_edge3 valid=%0b data=%h count=%0d exp 1/aa/1", o_out_valid, o_out_data, o_count); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (o_out_valid !== 1'b0 || o_count !== 8'd0) begin failures++; $display("FAIL lat_after_pop valid=%0b count=%0d exp 0/0", o_out_valid, o_count); end
    endtask

    task automatic test_stream_wrap();
        int sent = 0, got = 0, first = -1, last = -1, bad_ready = 0, bad_data = 0, bad_cnt = 0;
        do_reset();
        for (int c = 0; c < 300 && got < 100; c++) begin
            tick(sent < 100, 8'(sent), 1'b1, 1'b0);
            if (sent < 100 && !o_in_ready) bad_ready++;
            if (o_count !== 8'(exp_size)) bad_cnt++;
            if (o_push) sent++;
            if (o_pop) begin
                if (o_out_data !== 8'(got)) bad_data++;
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        checks++; if (got != 100) begin failures++; $display("FAIL stream_words got=%0d exp=100", got); end
        checks++; if (bad_data != 0) begin failures++; $display("FAIL stream_order out_of_order=%0d exp=0", bad_data); end
        checks++; if (bad_ready != 0) begin failures++; $display("FAIL stream_in_ready low_cycles=%0d exp=0", bad_ready); end
        checks++; if (bad_cnt != 0) begin failures++; $display("FAIL stream_count wrong_cycles=%0d exp=0", bad_cnt); end
        checks++; if (first != 3) begin failures++; $display("FAIL stream_first_cycle got=%0d exp=3", first); end
        checks++; if (last - first != 99) begin failures++; $display("FAIL stream_gapless span=%0d exp=99", last - first); end
    endtask

    task automatic test_full();
        int acc = 0, nexp = 1, bad = 0;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            tick(1'b1, 8'(acc), 1'b0, 1'b0);
            if (o_push) acc++;
        end
        checks++; if (acc != 66) begin failures++; $display("FAIL full_accepted got=%0d exp=66", acc); end
        tick(1'b1, 8'd66, 1'b0, 1'b0);
        checks++; if (o_count !== 8'd66 || o_in_ready !== 1'b0) begin
            failures++; $display("FAIL full_state count=%0d in_ready=%0b exp 66/0", o_count, o_in_ready); end
        tick(1'b1, 8'd66, 1'b1, 1'b0);
        checks++; if (o_in_ready !== 1'b0 || o_out_data !== 8'd0 || o_pop !== 1'b1) begin
            failures++; $display("FAIL full_pop in_ready=%0b data=%0d pop=%0b exp 0/0/1", o_in_ready, o_out_data, o_pop); end
        tick(1'b1, 8'd66, 1'b0, 1'b0);
        checks++; if (o_in_ready !== 1'b1 || o_push !== 1'b1) begin
            failures++; $display("FAIL full_reopen in_ready=%0b push=%0b exp 1/1", o_in_ready, o_push); end
        for (int c = 0; c < 200 && nexp <= 66; c++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (o_pop) begin
                if (o_out_data !== 8'(nexp)) bad++;
                nexp++;
            end
        end
        checks++; if (nexp != 67 || bad != 0) begin failures++; $display("FAIL full_drain next=%0d bad=%0d exp 67/0", nexp, bad); end
    endtask

    task automatic test_back_pressure();
        bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int   sent = 0, got = 0, bad_hold = 0, bad_data = 0;
        logic prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        do_reset();
        for (int c = 0; c < 200 && got < 16; c++) begin
            tick(sent < 16, 8'h10 + 8'(sent), pat[c % 6], 1'b0);
            if (prev_stall && (o_out_valid !== 1'b1 || o_out_data !== prev_data)) bad_hold++;
            if (o_pop) begin
                if (o_out_data !== 8'h10 + 8'(got)) bad_data++;
                got++;
            end
            if (o_push) sent++;
            prev_stall = o_out_valid & ~pat[c % 6];
            prev_data  = o_out_data;
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (got != 16 || bad_data != 0) begin failures++; $display("FAIL bp_sequence got=%0d bad=%0d exp 16/0", got, bad_data); end
        checks++; if (bad_hold != 0) begin failures++; $display("FAIL bp_hold unstable=%0d exp=0", bad_hold); end
        checks++; if (o_out_valid !== 1'b0 || o_count !== 8'd0) begin
            failures++; $display("FAIL bp_no_dup valid=%0b count=%0d exp 0/0", o_out_valid, o_count); end
    endtask

    task automatic test_flush();
        int waited = 0;
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (o_pop !== 1'b1 || o_out_data !== 8'h30) begin failures++; $display("FAIL flush_prepop data=%h exp=30", o_out_data); end
        tick(1'b1, 8'h77, 1'b0, 1'b1);
        checks++; if (o_we !== 1'b0) begin failures++; $display("FAIL flush_we_a got=%0b exp=0", o_we); end
        checks++; if (o_count !== 8'd5) begin failures++; $display("FAIL flush_before count=%0d exp=5", o_count); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (o_count !== 8'd0 || o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_after count=%0d valid=%0b in_ready=%0b exp 0/0/1", o_count, o_out_valid, o_in_ready); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (o_out_valid !== 1'b0 || o_count !== 8'd0) begin
            failures++; $display("FAIL flush_discard valid=%0b count=%0d exp 0/0", o_out_valid, o_count); end
        tick(1'b1, 8'h5A, 1'b0, 1'b0);
        o_pop = 1'b0;
        while (!o_pop && waited < 10) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            waited++;
        end
        checks++; if (o_pop !== 1'b1 || o_out_data !== 8'h5A) begin
            failures++; $display("FAIL flush_first_word pop=%0b data=%h exp 1/5a", o_pop, o_out_data); end
    endtask

    task automatic test_random();
        logic iv, ordy, fl;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            iv   = 1'($urandom);
            ordy = ((c / 250) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            fl   = ($urandom_range(0, 99) == 0);
            tick(iv, 8'($urandom), ordy, fl);
            checks++; if (o_count !== 8'(exp_size)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, o_count, exp_size); end
            if (o_pop) begin
                checks++; if (o_out_data !== exp_head) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, o_out_data, exp_head); end
            end
            checks++; if (o_in_ready ? (exp_size > 65) : (exp_size < 64)) begin
                failures++; $display("FAIL rand_in_ready cyc=%0d got=%0b held=%0d", c, o_in_ready, exp_size); end
            checks++; if (o_out_valid && exp_size == 0) begin failures++; $display("FAIL rand_out_valid cyc=%0d got=1 exp=0", c); end
        end
    endtask

`ifdef RAM_FIFO_OVF_FLAG_EN
    task automatic test_flags();
        do_reset();
        checks++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin failures++; $display("FAIL flags_reset ovf=%0b udf=%0b exp 0/0", ovf_err, udf_err); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (udf_err !== 1'b1) begin failures++; $display("FAIL flags_udf got=%0b exp=1", udf_err); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL flags_ovf_early got=%0b exp=0", ovf_err); end
        for (int c = 0; c < 80; c++) tick(1'b1, 8'(c), 1'b0, 1'b0);
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL flags_ovf got=%0b exp=1", ovf_err); end
        for (int c = 0; c < 100; c++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (ovf_err !== 1'b1 || udf_err !== 1'b1) begin failures++; $display("FAIL flags_sticky ovf=%0b udf=%0b exp 1/1", ovf_err, udf_err); end
        do_reset();
        checks++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin failures++; $display("FAIL flags_clear ovf=%0b udf=%0b exp 0/0", ovf_err, udf_err); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_basic_latency();
        test_stream_wrap();
        test_full();
        test_back_pressure();
        test_flush();
        test_random();
`ifdef RAM_FIFO_OVF_FLAG_EN
        test_flags();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that uses the existing 8-bit x 64-word true dual-port RAM as its storage.
- Port A is the write port: ram_we_a, ram_addr_a and ram_data_a are driven by this block.
- Port B is the read port: ram_addr_b is driven by this block, and the registered read data ram_q_b comes back into it.
- Presents valid/ready streams on both sides, with a 2-entry output buffer so sustained throughput is 1 word/cycle.

Parameters:
- DATA_W, 8: word width; must match the RAM.
- ADDR_W, 6: RAM address width; DEPTH = 2**ADDR_W = 64.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous clear of all contents
- in_data  input  DATA_W  write word
- in_valid  input  1  write request
- in_ready  output  1  space available
- out_data  output  DATA_W  head word
- out_valid  output  1  head word valid
- out_ready  input  1  consumer accepts
- count  output  ADDR_W+2  total words held (RAM + in-flight + output buffer)
- ram_data_a  output  DATA_W  to RAM data_a
- ram_addr_a  output  ADDR_W  to RAM addr_a
- ram_we_a  output  1  to RAM we_a
- ram_addr_b  output  ADDR_W  to RAM addr_b
- ram_we_b  output  1  tied 0
- ram_q_b  input  DATA_W  from RAM q_b; valid one cycle after addr_b is sampled

Behaviour:
- Reset (rst=1 at an edge) clears wr_ptr, rd_ptr, ram_cnt, rd_pend and the buffer. Outputs after reset: in_ready=1, out_valid=0, out_data=0, count=0, ram_we_a=0. rst takes priority over flush and over every other input.
- Push:
  - push = in_valid & in_ready; in_ready = (ram_cnt != DEPTH).
  - During push: ram_we_a=1, ram_addr_a=wr_ptr, ram_data_a=in_data (combinational). The RAM writes at the edge.
  - At that edge: wr_ptr+1, wrapping 63->0.
- Pop: pop = out_valid & out_ready. The buffer shifts so entry 1 becomes head; out_data always shows the head entry.
- Read issue:
  - rd_issue = (ram_cnt != 0) & (buf_cnt + rd_pend - pop < 2).
  - ram_addr_b = rd_ptr at all times.
  - On rd_issue: rd_ptr+1 (wrapping), rd_pend<=1. Otherwise rd_pend<=0.
- Fill: in the cycle with rd_pend=1, ram_q_b is written into the first free buffer slot, after any same-cycle pop is applied.
- ram_cnt next = ram_cnt + push - rd_issue. Simultaneous push and rd_issue leaves it unchanged.
- count = ram_cnt + rd_pend + buf_cnt. Maximum value is DEPTH+2 = 66.
- Latency: a push at edge k into an empty FIFO gives out_valid=1 after edge k+2 (issue at k+1, fill at k+2).
- Read-during-write: the read side only addresses committed words, because ram_cnt increments at the write edge. Port A and port B never target the same address in the same cycle with a stale result.
- Full (ram_cnt=64):
  - in_ready=0 and in_data is ignored.
  - A read issue in a cycle makes in_ready=1 in the next cycle; in_ready is not combinational on out_ready.
- Empty (count=0): out_valid=0, and out_ready is ignored.
- Throughput: with out_ready held at 1 and a continuous input, the steady state is 1 word/cycle.
- Flush (rst=0):
  - Same effect as reset on pointers, counts, rd_pend and buffer; any in-flight ram_q_b is discarded.
  - A push in the flush cycle is dropped, and ram_we_a is forced to 0 in that cycle.
- Reset mid-operation behaves as flush; RAM contents are not cleared but become unreachable.

Optional Feature:
- Macro: RAM_FIFO_OVF_FLAG_EN.
- Defined:
  - Adds output port ovf_err (1 bit) and output port udf_err (1 bit).
  - ovf_err is sticky; it is set at an edge where in_valid=1 and in_ready=0.
  - udf_err is sticky; it is set at an edge where out_ready=1 and out_valid=0.
  - Both are cleared only by rst or flush; both are 0 out of reset.
- Undefined: neither port exists, and the behaviour above is unchanged.

Test Plan:
- Basic latency: after reset, push 8'hAA at edge 1 -> out_valid=1 after edge 3, out_data=8'hAA, count=1. Pop -> count=0, out_valid=0.
- Streaming with wrap: push 0..99 continuously with out_ready=1 -> output sequence 0..99 in order with no gaps after the 2-cycle fill, and in_ready stays 1. Pointers wrap past 63.
- Full: out_ready=0, push 70 words -> exactly 66 accepted. count=66 and in_ready=0 once ram_cnt=64. A single pop -> in_ready=1 on the next cycle, and word 66 is then accepted.
- Back-pressure toggling: out_ready pattern 1,0,0,1,1,0 while pushing 8'h10..8'h1F -> no loss or duplication, and out_data is held stable while out_valid=1 & out_ready=0.
- Flush: 5 words stored and a read in flight, flush=1 together with in_valid=1 -> next cycle count=0, out_valid=0, ram_we_a was 0 in the flush cycle. The next push of 8'h5A emerges first.
- With RAM_FIFO_OVF_FLAG_EN: push while full -> ovf_err=1 and stays 1 until rst. out_ready=1 while empty -> udf_err=1.
